// File: rtl/frame_tx_streamer.sv
// rtl/frame_tx_streamer.sv - drains one frame from the tx buffer to the UART byte interface
module frame_tx_streamer #(
    parameter int          FRAME_BYTES = 5100,
    parameter logic [7:0]  HDR0        = 8'hAA,
    parameter logic [7:0]  HDR1        = 8'h55,
    parameter int          CNT_W       = $clog2(FRAME_BYTES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_ready,
    input  logic [7:0]       buf_data,
    output logic             buf_re,
    input  logic             tx_busy,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic             busy,
    output logic             frame_sent,
    output logic [CNT_W-1:0] byte_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_H0,
        SEND_H1,
        SEND_D,
        SEND_CK,
        WAIT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BYTES);

    state_t     state;
    state_t     state_next;
    state_t     last_sent;      // which SEND state launched the byte now on the wire
    logic       frame_ready_q;
    logic [7:0] checksum;
    logic       accept;
    logic       launch;
    logic       data_launch;
    logic [7:0] launch_byte;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-cycle launch/accept strobes
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        launch      = 1'b0;
        data_launch = 1'b0;
        launch_byte = 8'h00;
        case (state)
            IDLE: begin
                if (frame_ready && !frame_ready_q) begin
                    accept     = 1'b1;
                    state_next = SEND_H0;
                end
            end
            SEND_H0, SEND_H1, SEND_D, SEND_CK: begin
                if (!tx_busy) begin
                    launch     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // tx_start is still high in the first WAIT cycle; the UART has not
                // had a chance to raise tx_busy yet, so its level is not trusted.
                if (!tx_start && !tx_busy) begin
                    case (last_sent)
                        SEND_H0: state_next = SEND_H1;
                        SEND_H1: state_next = SEND_D;
                        SEND_D:  state_next = (byte_cnt < LAST_CNT) ? SEND_D : SEND_CK;
                        default: state_next = DONE;
                    endcase
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        case (state)
            SEND_H0: launch_byte = HDR0;
            SEND_H1: launch_byte = HDR1;
            SEND_D:  launch_byte = buf_data;
            SEND_CK: launch_byte = checksum;
            default: launch_byte = 8'h00;
        endcase
        data_launch = launch && (state == SEND_D);
    end

    // Datapath: pulses, held tx byte, running checksum and data byte count
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_ready_q <= 1'b0;
            tx_start      <= 1'b0;
            buf_re        <= 1'b0;
            tx_data       <= 8'h00;
            busy          <= 1'b0;
            byte_cnt      <= '0;
            checksum      <= 8'h00;
            last_sent     <= IDLE;
        end else begin
            frame_ready_q <= frame_ready;
            tx_start      <= launch;
            // buf_re lands one cycle after buf_data was captured, so the pointer
            // only moves once the current byte is safely held in tx_data.
            buf_re        <= data_launch;
            if (accept) begin
                busy     <= 1'b1;
                byte_cnt <= '0;
                checksum <= 8'h00;
            end
            if (launch) begin
                tx_data   <= launch_byte;
                last_sent <= state;
            end
            if (data_launch) begin
                checksum <= checksum + buf_data;
                byte_cnt <= byte_cnt + 1'b1;
            end
            if (state == DONE) begin
                busy <= 1'b0;
            end
        end
    end

    assign frame_sent = (state == DONE);

endmodule
